// File: rtl/serial_magnitude_comparator_ctrl.sv
// Byte-serial magnitude comparator: walks two WIDTH-bit operands MSB byte first
// through one shared 8-bit comparator, stopping at the first unequal byte.

module eight_bit_comparator (
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  output logic       o_LT,
  output logic       o_GT,
  output logic       o_EQ
);
  assign o_LT = (i_A < i_B);
  assign o_GT = (i_A > i_B);
  assign o_EQ = (i_A == i_B);
endmodule

module serial_magnitude_comparator_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic             i_SIGNED,
  input  logic [WIDTH-1:0] i_OPERAND_A,
  input  logic [WIDTH-1:0] i_OPERAND_B,
  input  logic             i_CLEAR,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_LT,
  output logic             o_GT,
  output logic             o_EQ
);

  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(BYTES - 1);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_magnitude_comparator_ctrl: WIDTH must be a multiple of 8 and at least 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic [7:0] byte_a, byte_b;
  logic       cmp_lt, cmp_gt, cmp_eq;
  logic       flip_msb;

  // Signed compare = unsigned compare after flipping the sign bit of the top byte only.
  assign flip_msb = signed_q && (idx_q == TOP_IDX);
  assign byte_a   = a_q[idx_q*8 +: 8] ^ {flip_msb, 7'b0};
  assign byte_b   = b_q[idx_q*8 +: 8] ^ {flip_msb, 7'b0};

  eight_bit_comparator u_cmp (
    .i_A  (byte_a),
    .i_B  (byte_b),
    .o_LT (cmp_lt),
    .o_GT (cmp_gt),
    .o_EQ (cmp_eq)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= TOP_IDX;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    if (i_CLEAR) begin
      state_d = ST_IDLE;
      idx_d   = TOP_IDX;
      lt_d    = 1'b0;
      gt_d    = 1'b0;
      eq_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_VALID) begin
            state_d  = ST_COMPARE;
            idx_d    = TOP_IDX;
            a_d      = i_OPERAND_A;
            b_d      = i_OPERAND_B;
            signed_d = i_SIGNED;
            lt_d     = 1'b0;
            gt_d     = 1'b0;
            eq_d     = 1'b0;
          end
        end
        ST_COMPARE: begin
          if (!cmp_eq) begin
            state_d = ST_DONE;
            lt_d    = cmp_lt;
            gt_d    = cmp_gt;
            eq_d    = 1'b0;
          end else if (idx_q == '0) begin
            state_d = ST_DONE;
            eq_d    = 1'b1;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_READY = (state_q == ST_IDLE);
    o_BUSY  = (state_q != ST_IDLE);
    o_DONE  = (state_q == ST_DONE);
    o_LT    = lt_q;
    o_GT    = gt_q;
    o_EQ    = eq_q;
  end

endmodule

// File: tb/tb_serial_magnitude_comparator_ctrl.sv
// Directed bench for serial_magnitude_comparator_ctrl at WIDTH=32.

module tb_serial_magnitude_comparator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        clr = 1'b0;
  logic        ready, busy, done, lt, gt, eq;

  int checks = 0;
  int failures = 0;

  serial_magnitude_comparator_ctrl #(.WIDTH(32)) dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_VALID     (valid),
    .o_READY     (ready),
    .i_SIGNED    (sgn),
    .i_OPERAND_A (op_a),
    .i_OPERAND_B (op_b),
    .i_CLEAR     (clr),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_LT        (lt),
    .o_GT        (gt),
    .o_EQ        (eq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Present a request for one edge, then scramble the inputs to prove they were latched.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    valid = 1'b1; op_a = a; op_b = b; sgn = s;
    @(posedge clk); #1;
    valid = 1'b0; op_a = ~a; op_b = ~b; sgn = ~s;
  endtask

  // Count edges from acceptance (inclusive) until o_DONE; flag any early ready/flag activity.
  task automatic wait_done(output int lat, output bit bad);
    lat = 1; bad = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (ready !== 1'b0 || busy !== 1'b1 || {lt, gt, eq} !== 3'b000) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (ready !== 1'b0) bad = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({ready, busy, done, lt, gt, eq} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=100000", {ready, busy, done, lt, gt, eq});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=100", {ready, busy, done});
    end
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int exp_lat, input logic [2:0] exp_f);
    int lat; bit bad;
    do_req(a, b, s);
    wait_done(lat, bad);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
    end
    checks++;
    if ({lt, gt, eq} !== exp_f) begin
      failures++;
      $display("FAIL %s_flags ltgteq got=%b exp=%b", name, {lt, gt, eq}, exp_f);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s_in_progress got=ready_or_flag_active exp=busy_flags_clear", name);
    end
    @(posedge clk); #1;
    checks++;
    if ({ready, done, lt, gt, eq} !== {2'b10, exp_f}) begin
      failures++;
      $display("FAIL %s_held got=%b exp=%b", name, {ready, done, lt, gt, eq}, {2'b10, exp_f});
    end
  endtask

  task automatic test_unsigned();
    run_one("u_lt_full", 32'h12345678, 32'h12345679, 1'b0, 5, 3'b100);
    run_one("u_gt_early", 32'hFF000000, 32'h01FFFFFF, 1'b0, 2, 3'b010);
  endtask

  task automatic test_signed();
    run_one("s_neg_lt", 32'h80000000, 32'h00000001, 1'b1, 2, 3'b100);
    run_one("u_neg_gt", 32'h80000000, 32'h00000001, 1'b0, 2, 3'b010);
    run_one("s_low_bytes", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 5, 3'b010);
    run_one("s_pos_lt", 32'h00000000, 32'h7F000000, 1'b1, 2, 3'b100);
  endtask

  task automatic test_equal();
    run_one("u_eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5, 3'b001);
    run_one("s_eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5, 3'b001);
  endtask

  task automatic test_clear();
    bit saw_done;
    do_req(32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if ({ready, busy, done, lt, gt, eq} !== 6'b100000) begin
      failures++;
      $display("FAIL clear_abort got=%b exp=100000", {ready, busy, done, lt, gt, eq});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL clear_no_done got=done_pulsed exp=no_done");
    end
    @(negedge clk);
    valid = 1'b1; clr = 1'b1; op_a = 32'h1; op_b = 32'h0;
    @(posedge clk); #1;
    valid = 1'b0; clr = 1'b0;
    checks++;
    if ({ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL clear_beats_valid got=%b exp=10", {ready, busy});
    end
    run_one("after_clear", 32'h00000001, 32'h00000000, 1'b0, 5, 3'b010);
  endtask

  task automatic test_async_reset();
    run_one("pre_rst", 32'h00000005, 32'h00000003, 1'b0, 5, 3'b010);
    do_req(32'h11111111, 32'h11111111, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, lt, gt, eq} !== 6'b100000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=100000", {ready, busy, done, lt, gt, eq});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, done, lt, gt, eq} !== 5'b10000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=10000", {ready, done, lt, gt, eq});
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    valid = 1'b1; sgn = 1'b0; op_a = 32'hFF000000; op_b = 32'h01FFFFFF;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept1 busy got=%b exp=1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, lt, gt, eq} !== 4'b1010) begin
      failures++;
      $display("FAIL b2b_done1 got=%b exp=1010", {done, lt, gt, eq});
    end
    @(posedge clk); #1;
    checks++;
    if ({ready, done, gt} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_idle_gap got=%b exp=101", {ready, done, gt});
    end
    op_a = 32'h00000000; op_b = 32'h10000000;
    @(posedge clk); #1;
    checks++;
    if ({busy, lt, gt, eq} !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_accept2 got=%b exp=1000", {busy, lt, gt, eq});
    end
    valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({done, lt, gt, eq} !== 4'b1100) begin
      failures++;
      $display("FAIL b2b_done2 got=%b exp=1100", {done, lt, gt, eq});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    test_reset();
    test_unsigned();
    test_signed();
    test_equal();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
